// File: rtl/arcade_input_pkg.sv
// arcade_input_pkg: shared scan codes, rotation enum, direction indices and joystick bit-offset helpers.
// Contents:
//   SC_*        9-bit {extended, scan code} values recognised by the key tracker
//   rot_e       screen orientation (ROT_0/90/180/270)
//   DIR_*       bit positions of R/L/D/U in the MiSTer joystick word
//   joy_*()     start1/start2/coin bit offsets as a function of BUTTONS
//   rotate()    orientation remap of a {U,D,L,R} nibble
package arcade_input_pkg;

    localparam logic [8:0] SC_UP   = 9'h175;
    localparam logic [8:0] SC_DN   = 9'h172;
    localparam logic [8:0] SC_LT   = 9'h16B;
    localparam logic [8:0] SC_RT   = 9'h174;
    localparam logic [8:0] SC_B0A  = 9'h029;
    localparam logic [8:0] SC_B0B  = 9'h014;
    localparam logic [8:0] SC_B1   = 9'h011;
    localparam logic [8:0] SC_B2   = 9'h012;
    localparam logic [8:0] SC_B3   = 9'h01A;
    localparam logic [8:0] SC_ST1  = 9'h005;
    localparam logic [8:0] SC_ST2  = 9'h006;
    localparam logic [8:0] SC_COIN = 9'h02E;

    typedef enum logic [1:0] {ROT_0, ROT_90, ROT_180, ROT_270} rot_e;

    localparam int DIR_R = 0;
    localparam int DIR_L = 1;
    localparam int DIR_D = 2;
    localparam int DIR_U = 3;

    function automatic int joy_start1(input int buttons);
        return 4 + buttons;
    endfunction

    function automatic int joy_start2(input int buttons);
        return 5 + buttons;
    endfunction

    function automatic int joy_coin(input int buttons);
        return 6 + buttons;
    endfunction

    function automatic logic [3:0] rotate(input logic [3:0] d, input rot_e r);
        logic [3:0] o;
        o = d;
        case (r)
            ROT_90: begin
                o[DIR_U] = d[DIR_L];
                o[DIR_D] = d[DIR_R];
                o[DIR_L] = d[DIR_D];
                o[DIR_R] = d[DIR_U];
            end
            ROT_180: begin
                o[DIR_U] = d[DIR_D];
                o[DIR_D] = d[DIR_U];
                o[DIR_L] = d[DIR_R];
                o[DIR_R] = d[DIR_L];
            end
            ROT_270: begin
                o[DIR_U] = d[DIR_R];
                o[DIR_D] = d[DIR_L];
                o[DIR_L] = d[DIR_U];
                o[DIR_R] = d[DIR_D];
            end
            default: o = d;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: turns PS/2 make/break toggle events into a held key-state word in MiSTer joystick layout.
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   ps2_key  in   [10] event toggle, [9] pressed, [8] extended, [7:0] scan code
//   keys     out  key states, same bit layout as a joystick word (R,L,D,U,buttons,start1,start2,coin)
module ps2_key_tracker #(
    parameter int BUTTONS = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] ps2_key,
    output logic [15:0] keys
);
    import arcade_input_pkg::*;

    logic       armed;
    logic       old_tgl;
    logic       hit;
    logic [3:0] idx;

    // Buttons beyond BUTTONS decode to no hit so their keys never latch.
    always_comb begin
        hit = 1'b1;
        idx = '0;
        case (ps2_key[8:0])
            SC_UP:          idx = 4'(DIR_U);
            SC_DN:          idx = 4'(DIR_D);
            SC_LT:          idx = 4'(DIR_L);
            SC_RT:          idx = 4'(DIR_R);
            SC_B0A, SC_B0B: idx = 4'd4;
            SC_B1:          begin idx = 4'd5; hit = BUTTONS > 1; end
            SC_B2:          begin idx = 4'd6; hit = BUTTONS > 2; end
            SC_B3:          begin idx = 4'd7; hit = BUTTONS > 3; end
            SC_ST1:         idx = 4'(joy_start1(BUTTONS));
            SC_ST2:         idx = 4'(joy_start2(BUTTONS));
            SC_COIN:        idx = 4'(joy_coin(BUTTONS));
            default:        hit = 1'b0;
        endcase
    end

    // The first clock after reset only captures the toggle level, so a stale
    // toggle state present at reset release is never mistaken for an event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed   <= 1'b0;
            old_tgl <= 1'b0;
            keys    <= '0;
        end else begin
            armed   <= 1'b1;
            old_tgl <= ps2_key[10];
            if (armed && ps2_key[10] != old_tgl && hit)
                keys[idx] <= ps2_key[9];
        end
    end

endmodule

// File: rtl/arcade_input_mapper.sv
// arcade_input_mapper: merges PS/2 keys and joysticks, rotates directions, routes players and times the coin pulse.
// Ports:
//   I_CLK_24576M  in   system clock
//   I_RESETn      in   asynchronous active-low reset
//   I_PS2_KEY     in   PS/2 event word from the HPS
//   I_JOY0/1      in   MiSTer joystick words
//   I_ROT         in   screen orientation (0/90/180/270)
//   I_SPLIT       in   1: JOY1 drives player 2 only
//   I_AF_EN       in   autofire request for button 0
//   O_P1_n/O_P2_n out  active-low {buttons, U, D, L, R}
//   O_START_n     out  active-low {start2, start1}
//   O_COIN_n      out  active-low coin pulse
// Optional feature: define AUTOFIRE_EN to build the button-0 autofire generator.
module arcade_input_mapper #(
    parameter int PLAYERS    = 2,
    parameter int BUTTONS    = 1,
    parameter int COIN_PULSE = 1228800,
    parameter int AF_PERIOD  = 1638400
) (
    input  logic                 I_CLK_24576M,
    input  logic                 I_RESETn,
    input  logic [10:0]          I_PS2_KEY,
    input  logic [15:0]          I_JOY0,
    input  logic [15:0]          I_JOY1,
    input  logic [1:0]           I_ROT,
    input  logic                 I_SPLIT,
    input  logic                 I_AF_EN,
    output logic [BUTTONS+3:0]   O_P1_n,
    output logic [BUTTONS+3:0]   O_P2_n,
    output logic [1:0]           O_START_n,
    output logic                 O_COIN_n
);
    import arcade_input_pkg::*;

    localparam int W  = 4 + BUTTONS;
    localparam int S1 = joy_start1(BUTTONS);
    localparam int S2 = joy_start2(BUTTONS);
    localparam int CN = joy_coin(BUTTONS);
    localparam int CW = $clog2(COIN_PULSE + 1);
    localparam logic [CW-1:0] CLOAD = CW'(COIN_PULSE - 1);

    typedef enum logic [1:0] {IDLE, PULSE, HOLD} coin_e;

    logic [15:0]   kbd;
    logic [15:0]   src1;
    logic [15:0]   src2;
    logic [15:0]   all_src;
    logic          af_on;
    logic          af_phase;
    logic          req;
    logic          req_q;
    coin_e         state;
    logic [CW-1:0] cnt;
    logic          unused;

    ps2_key_tracker #(.BUTTONS(BUTTONS)) u_keys (
        .clk     (I_CLK_24576M),
        .rst_n   (I_RESETn),
        .ps2_key (I_PS2_KEY),
        .keys    (kbd)
    );

    assign src1    = kbd | I_JOY0 | (I_SPLIT ? 16'h0 : I_JOY1);
    assign src2    = I_SPLIT ? I_JOY1 : src1;
    assign all_src = kbd | I_JOY0 | I_JOY1;
    assign req     = all_src[S1] | all_src[S2] | all_src[CN];
    assign unused  = ^{src1, src2, all_src, I_AF_EN};

`ifdef AUTOFIRE_EN
    localparam int AW = $clog2(AF_PERIOD + 1);
    logic [AW-1:0] af_cnt;

    assign af_on = I_AF_EN;

    always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
        if (!I_RESETn) begin
            af_cnt   <= '0;
            af_phase <= 1'b0;
        end else if (af_cnt == AW'(AF_PERIOD - 1)) begin
            af_cnt   <= '0;
            af_phase <= ~af_phase;
        end else begin
            af_cnt <= af_cnt + 1'b1;
        end
    end
`else
    assign af_on    = 1'b0;
    assign af_phase = 1'b0;
`endif

    // Active-high player word: autofire gates a held button 0, then directions are rotated.
    function automatic logic [W-1:0] map(input logic [15:0] s, input rot_e r, input logic on, input logic ph);
        logic [BUTTONS-1:0] b;
        b    = s[4 +: BUTTONS];
        b[0] = (on && b[0]) ? ph : b[0];
        return {b, rotate(s[3:0], r)};
    endfunction

    always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
        if (!I_RESETn) begin
            O_P1_n    <= '1;
            O_P2_n    <= '1;
            O_START_n <= '1;
        end else begin
            O_P1_n    <= ~map(src1, rot_e'(I_ROT), af_on, af_phase);
            O_P2_n    <= (PLAYERS > 1) ? ~map(src2, rot_e'(I_ROT), af_on, af_phase) : '1;
            O_START_n <= ~{all_src[S2], all_src[S1]};
        end
    end

    // One pulse per request rising edge; HOLD waits for release so a held
    // start/coin cannot retrigger.
    always_ff @(posedge I_CLK_24576M or negedge I_RESETn) begin
        if (!I_RESETn) begin
            state    <= IDLE;
            cnt      <= '0;
            req_q    <= 1'b0;
            O_COIN_n <= 1'b1;
        end else begin
            req_q <= req;
            case (state)
                IDLE: if (req && !req_q) begin
                    state    <= PULSE;
                    cnt      <= CLOAD;
                    O_COIN_n <= 1'b0;
                end
                PULSE: if (cnt == '0) begin
                    state    <= HOLD;
                    O_COIN_n <= 1'b1;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                HOLD: if (!req) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arcade_input_mapper.sv
// tb_arcade_input_mapper: directed table and sequence checks for arcade_input_mapper (BUTTONS=4, COIN_PULSE=8, AF_PERIOD=4).
module tb_arcade_input_mapper;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] ps2 = 11'h400;
    logic [15:0] j0 = '0;
    logic [15:0] j1 = '0;
    logic [1:0]  rot = '0;
    logic        split = 1'b0;
    logic        af = 1'b0;
    logic [7:0]  p1;
    logic [7:0]  p2;
    logic [1:0]  st;
    logic        coin;

    int passed = 0;
    int total = 0;

    typedef struct {
        logic [15:0] j0;
        logic [15:0] j1;
        logic [1:0]  rot;
        logic        split;
        logic [7:0]  e1;
        logic [7:0]  e2;
        logic [1:0]  es;
    } vec_t;

    vec_t v[13];

    arcade_input_mapper #(
        .PLAYERS    (2),
        .BUTTONS    (4),
        .COIN_PULSE (8),
        .AF_PERIOD  (4)
    ) dut (
        .I_CLK_24576M (clk),
        .I_RESETn     (rst_n),
        .I_PS2_KEY    (ps2),
        .I_JOY0       (j0),
        .I_JOY1       (j1),
        .I_ROT        (rot),
        .I_SPLIT      (split),
        .I_AF_EN      (af),
        .O_P1_n       (p1),
        .O_P2_n       (p2),
        .O_START_n    (st),
        .O_COIN_n     (coin)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        j0 = '0;
        j1 = '0;
        rot = '0;
        split = 1'b0;
        af = 1'b0;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    initial begin
        int   low;
        int   falls;
        int   tog;
        int   bad;
        logic prev;
        logic s[32];

        v[0]  = '{16'h0000, 16'h0000, 2'd0, 1'b0, 8'hFF, 8'hFF, 2'b11};
        v[1]  = '{16'h0002, 16'h0000, 2'd0, 1'b0, 8'hFD, 8'hFD, 2'b11};
        v[2]  = '{16'h0002, 16'h0000, 2'd1, 1'b0, 8'hF7, 8'hF7, 2'b11};
        v[3]  = '{16'h0002, 16'h0000, 2'd2, 1'b0, 8'hFE, 8'hFE, 2'b11};
        v[4]  = '{16'h0002, 16'h0000, 2'd3, 1'b0, 8'hFB, 8'hFB, 2'b11};
        v[5]  = '{16'h0000, 16'h0010, 2'd0, 1'b1, 8'hFF, 8'hEF, 2'b11};
        v[6]  = '{16'h0000, 16'h0010, 2'd0, 1'b0, 8'hEF, 8'hEF, 2'b11};
        v[7]  = '{16'h0008, 16'h0001, 2'd0, 1'b1, 8'hF7, 8'hFE, 2'b11};
        v[8]  = '{16'h0008, 16'h0001, 2'd1, 1'b1, 8'hFE, 8'hFB, 2'b11};
        v[9]  = '{16'h00E0, 16'h0000, 2'd0, 1'b0, 8'h1F, 8'h1F, 2'b11};
        v[10] = '{16'h0100, 16'h0200, 2'd0, 1'b1, 8'hFF, 8'hFF, 2'b00};
        v[11] = '{16'h0000, 16'h0200, 2'd0, 1'b1, 8'hFF, 8'hFF, 2'b01};
        v[12] = '{16'h0000, 16'h0001, 2'd2, 1'b0, 8'hFD, 8'hFD, 2'b11};

        do_reset();
        tick(5);
        check("reset_p1", 16'(p1), 16'hFF);
        check("reset_p2", 16'(p2), 16'hFF);
        check("reset_start", 16'(st), 16'h3);
        check("reset_coin", 16'(coin), 16'h1);

        ps2 = {1'b0, 1'b1, 1'b1, 8'h75};
        tick(1);
        check("ps2_make_lat1", 16'(p1[3]), 16'h1);
        tick(1);
        check("ps2_make_up", 16'(p1[3]), 16'h0);
        tick(3);
        check("ps2_hold_up", 16'(p1), 16'hF7);
        ps2 = {1'b1, 1'b0, 1'b1, 8'h75};
        tick(1);
        check("ps2_break_lat1", 16'(p1[3]), 16'h0);
        tick(1);
        check("ps2_break_up", 16'(p1), 16'hFF);
        ps2 = {1'b0, 1'b1, 1'b0, 8'h75};
        tick(3);
        check("ps2_unmatched", 16'(p1), 16'hFF);
        ps2 = {1'b1, 1'b1, 1'b0, 8'h29};
        tick(1);
        ps2 = {1'b0, 1'b0, 1'b0, 8'h29};
        tick(1);
        check("ps2_make_btn0", 16'(p1), 16'hEF);
        tick(2);
        check("ps2_make_break_final", 16'(p1), 16'hFF);

        for (int i = 0; i < 13; i++) begin
            j0 = v[i].j0;
            j1 = v[i].j1;
            rot = v[i].rot;
            split = v[i].split;
            tick(1);
            check($sformatf("vec%0d_p1", i), 16'(p1), 16'(v[i].e1));
            check($sformatf("vec%0d_p2", i), 16'(p2), 16'(v[i].e2));
            check($sformatf("vec%0d_start", i), 16'(st), 16'(v[i].es));
        end

        do_reset();
        tick(2);
        j0 = 16'h0100;
        tick(1);
        check("coin_fall", 16'(coin), 16'h0);
        low = 1;
        falls = 1;
        prev = coin;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (!coin) low++;
            if (prev && !coin) falls++;
            prev = coin;
        end
        check("coin_low_len", 16'(low), 16'd8);
        check("coin_pulses", 16'(falls), 16'd1);
        j0 = '0;
        tick(2);
        check("coin_released", 16'(coin), 16'h1);
        j0 = 16'h0100;
        low = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (!coin) low++;
        end
        check("coin_repress_len", 16'(low), 16'd8);

        j0 = '0;
        tick(2);
        j0 = 16'h0400;
        tick(3);
        check("coin_mid_pulse", 16'(coin), 16'h0);
        #2 rst_n = 1'b0;
        #1;
        check("coin_async_reset", 16'(coin), 16'h1);
        j0 = '0;
        tick(1);
        rst_n = 1'b1;
        tick(2);
        check("coin_after_reset", 16'(coin), 16'h1);
        j0 = 16'h0400;
        tick(1);
        check("coin_idle_after_reset", 16'(coin), 16'h0);

        do_reset();
        tick(1);
        af = 1'b1;
        j0 = 16'h0010;
        for (int i = 0; i < 32; i++) begin
            tick(1);
            s[i] = p1[4];
        end
`ifdef AUTOFIRE_EN
        tog = 0;
        bad = 0;
        for (int i = 1; i < 32; i++) if (s[i] != s[i-1]) tog++;
        for (int i = 4; i < 32; i++) if (s[i] == s[i-4]) bad++;
        check("af_half_period", 16'(bad), 16'd0);
        check("af_toggles", 16'(tog >= 7 && tog <= 8), 16'd1);
`else
        tog = 0;
        for (int i = 0; i < 32; i++) if (s[i]) tog++;
        check("af_disabled_steady", 16'(tog), 16'd0);
`endif
        af = 1'b0;
        tick(2);
        check("af_off_passthru", 16'(p1), 16'hEF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/arcade_input_mapper.md
# arcade_input_mapper

Parametrised control-input front end between the HPS joystick/PS/2 feed and an arcade core's active-low player inputs. It tracks PS/2 make/break events and merges them with one or two joysticks. It remaps directions for four screen orientations and can route controls per player for cocktail play. It also generates a timed, debounced coin pulse. It replaces the inline key decode, joystick OR and orientation swap in the top-level emu wrapper.

## Interface
- PLAYERS, 2: number of player output sets (1 or 2).
- BUTTONS, 1: fire buttons per player (1..4).
- COIN_PULSE, 1228800: coin assertion length in clocks (50 ms at 24.576 MHz); minimum 1.
- AF_PERIOD, 1638400: autofire half-period in clocks (only used with AUTOFIRE_EN).

Ports:
- I_CLK_24576M  in  1  system clock; all logic on rising edge.
- I_RESETn  in  1  asynchronous, active-low reset.
- I_PS2_KEY  in  11  [10] event toggle, [9] pressed, [8] extended, [7:0] scan code.
- I_JOY0, I_JOY1  in  16  MiSTer joysticks: [0] R, [1] L, [2] D, [3] U, [4+k] button k, [4+BUTTONS] start1, [5+BUTTONS] start2, [6+BUTTONS] coin.
- I_ROT  in  2  0 none, 1 90°, 2 180°, 3 270°.
- I_SPLIT  in  1  1: JOY1 drives player 2 only; 0: JOY0|JOY1|keyboard drive every player.
- I_AF_EN  in  1  autofire request for button 0.
- O_P1_n, O_P2_n  out  4+BUTTONS  active-low {buttons[BUTTONS-1:0], U, D, L, R}. O_P2_n is constant all-ones when PLAYERS=1.
- O_START_n  out  2  active-low start1, start2.
- O_COIN_n  out  1  active-low coin pulse.

## Operation
- Key tracker: `armed` and `old_tgl` both reset to 0. The first clock after reset loads `old_tgl` and sets `armed` without decoding. After that, any cycle where [10] != `old_tgl` is an event. Key state bit <= [9] for a matching {[8],[7:0]}; unmatched codes are ignored.
- Key map (P1 only): E075 U, E072 D, E06B L, E074 R; 029 or 014 btn0; 011 btn1; 012 btn2; 01A btn3; 005 start1; 006 start2; 02E coin. Buttons at index >= BUTTONS are ignored.
- Merge: `src1` = kbd | JOY0 | (I_SPLIT ? 0 : JOY1). `src2` = I_SPLIT ? JOY1 : `src1`. Starts and coin always OR all sources.
- Rotation is applied per player to {U,D,L,R}:
  - 1: U<-L, D<-R, L<-D, R<-U.
  - 2: U<-D, D<-U, L<-R, R<-L.
  - 3: U<-R, D<-L, L<-U, R<-D.
- Coin FSM states:
  - IDLE: a rising edge of the coin request (start1|start2|coin, any source) -> PULSE, counter loaded with COIN_PULSE-1.
  - PULSE: O_COIN_n=0; the counter decrements and at 0 -> HOLD.
  - HOLD: O_COIN_n=1; request low -> IDLE.
  - Request edges during PULSE or HOLD are ignored.
  - Counter width is $clog2(COIN_PULSE+1).
- Starts pass through with no gating; the game samples start after coin.

## Timing
- Reset values: every output is 1 (inactive), key states 0, FSM IDLE, counters 0.
- Joystick to output: 1 clock (all outputs registered).
- PS/2 event to output: 2 clocks (key-state register, then output register).
- O_COIN_n falls 1 clock after the request rising edge is sampled and stays low for exactly COIN_PULSE clocks.
- I_ROT and I_SPLIT take effect on the next output update; no glitch suppression beyond the output register.
- Reset mid-PULSE: O_COIN_n returns to 1 asynchronously and the FSM goes to IDLE.
- A make and a break for the same key on consecutive events give the final state of the last event.

## Configuration
- AUTOFIRE_EN defined:
  - A free-running counter toggles `af_phase` every AF_PERIOD clocks; it resets to phase 0 with the output released.
  - When I_AF_EN=1 and button0 is held, the button0 output equals `af_phase`.
  - When I_AF_EN=0 or the button is released, button0 passes through unchanged.
- AUTOFIRE_EN undefined: there is no counter, I_AF_EN is ignored, and button0 always passes through.

## Structure
- Package arcade_input_pkg: scan-code localparams, rotation enum (ROT_0/90/180/270), direction bit indices, the JOY bit-offset function of BUTTONS.
- Sub-module ps2_key_tracker: toggle edge detect, arming, and key-state register vector. It is instantiated once.
- Rotation, merge, coin FSM and autofire stay in the top.

## Test plan
- Reset release with I_PS2_KEY[10]=1 and no later toggle change -> no key state set; all outputs stay 1.
- PS/2 event {E075, pressed} at I_ROT=0 -> O_P1_n[U]=0 two clocks later. Break event -> O_P1_n[U]=1 two clocks after the break.
- JOY0[1] (L) held, I_ROT=1 -> U asserted. I_ROT=2 -> R asserted. I_ROT=3 -> D asserted. Each change is seen 1 clock after I_ROT changes.
- I_SPLIT=1, JOY1[4] held -> O_P2_n btn0=0 and O_P1_n btn0=1. I_SPLIT=0 -> both btn0 outputs 0.
- JOY0 start1 held 3·COIN_PULSE clocks, COIN_PULSE=8 -> O_COIN_n low for exactly 8 clocks once, with no second pulse until release and re-press.
- AUTOFIRE_EN, AF_PERIOD=4, I_AF_EN=1, btn0 held 32 clocks -> button0 output alternates every 4 clocks. Without the macro it is steady 0.
